// File: rtl/ram_port_arbiter_if.sv
// Client handshake and RAM-side bus bundle for the two-client single-port RAM arbiter.
// The slave modport is the arbiter's view; master is the clients plus the RAM.
interface ram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_cs_n;
    logic                  ram_we_n;
    logic                  ram_oe;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_wdata_en;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_addr, ram_cs_n, ram_we_n, ram_oe, ram_wdata, ram_wdata_en,
        input  ram_rdata,
        output busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_addr, ram_cs_n, ram_we_n, ram_oe, ram_wdata, ram_wdata_en,
        output ram_rdata,
        input  busy
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter/sequencer turning two client req/gnt/rvalid ports into
// single-port RAM cycles: write = IDLE->ACCESS, read = IDLE->ACCESS->RD_WAIT.

// Per-client read-return register: captures RAM data and pulses rvalid.
module ram_port_arbiter_rport #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cap_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= cap_i;
            if (cap_i) rdata_q <= rdata_i;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
endmodule

module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    ram_port_arbiter_if.slave   bus
);
    localparam int NUM_CLIENTS = 2;

    typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    logic [NUM_CLIENTS-1:0] req;
    req_t [NUM_CLIENTS-1:0] creq;

    assign req     = {bus.m1_req, bus.m0_req};
    assign creq[0] = '{we: bus.m0_we, addr: bus.m0_addr, wdata: bus.m0_wdata};
    assign creq[1] = '{we: bus.m1_we, addr: bus.m1_addr, wdata: bus.m1_wdata};

    state_t                 state_q;
    logic                   prio_q;
    logic                   win_q;
    logic                   win_d;
    req_t                   cur_q;
    logic [NUM_CLIENTS-1:0] gnt_q;
    logic [ADDR_WIDTH-1:0]  ram_addr_q;
    logic [DATA_WIDTH-1:0]  ram_wdata_q;
    logic                   ram_cs_n_q;
    logic                   ram_we_n_q;
    logic                   ram_oe_q;
    logic                   ram_wdata_en_q;
    logic                   busy_q;

    // A lone requester wins outright; prio only breaks ties.
    always_comb begin
        win_d = req[1];
        if (&req) win_d = prio_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            prio_q         <= 1'b0;
            win_q          <= 1'b0;
            cur_q          <= '0;
            gnt_q          <= '0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
            ram_cs_n_q     <= 1'b1;
            ram_we_n_q     <= 1'b1;
            ram_oe_q       <= 1'b0;
            ram_wdata_en_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            gnt_q          <= '0;
            ram_cs_n_q     <= 1'b1;
            ram_we_n_q     <= 1'b1;
            ram_oe_q       <= 1'b0;
            ram_wdata_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        // Outputs for the ACCESS cycle are set up here so they are registered.
                        state_q       <= ACCESS;
                        win_q         <= win_d;
                        cur_q         <= creq[win_d];
                        prio_q        <= ~win_d;
                        gnt_q[win_d]  <= 1'b1;
                        ram_cs_n_q    <= 1'b0;
                        ram_addr_q    <= creq[win_d].addr;
                        busy_q        <= 1'b1;
                        if (creq[win_d].we) begin
                            ram_we_n_q     <= 1'b0;
                            ram_wdata_en_q <= 1'b1;
                            ram_wdata_q    <= creq[win_d].wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cur_q.we) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q    <= RD_WAIT;
                        ram_cs_n_q <= 1'b0;
                        ram_oe_q   <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    logic [NUM_CLIENTS-1:0]                 rvalid;
    logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] rdata;

    // Data on the RAM bus is captured at the end of RD_WAIT into the winner only.
    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_rport
        ram_port_arbiter_rport #(.DATA_WIDTH(DATA_WIDTH)) u_rport (
            .clk      (clk),
            .rst      (rst),
            .cap_i    ((state_q == RD_WAIT) && (win_q == 1'(i))),
            .rdata_i  (bus.ram_rdata),
            .rvalid_o (rvalid[i]),
            .rdata_o  (rdata[i])
        );
    end

    assign bus.m0_gnt       = gnt_q[0];
    assign bus.m1_gnt       = gnt_q[1];
    assign bus.m0_rvalid    = rvalid[0];
    assign bus.m1_rvalid    = rvalid[1];
    assign bus.m0_rdata     = rdata[0];
    assign bus.m1_rdata     = rdata[1];
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_cs_n     = ram_cs_n_q;
    assign bus.ram_we_n     = ram_we_n_q;
    assign bus.ram_oe       = ram_oe_q;
    assign bus.ram_wdata    = ram_wdata_q;
    assign bus.ram_wdata_en = ram_wdata_en_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port RAM model.
module tb_ram_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    ram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // RAM model: write on active cs/we with bus driven, combinational read while oe.
    logic [31:0] mem [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    assign bus.ram_rdata = (!bus.ram_cs_n && bus.ram_oe) ? mem[bus.ram_addr] : 32'h0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (!bus.ram_cs_n && !bus.ram_we_n && bus.ram_wdata_en) mem[bus.ram_addr] <= bus.ram_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0001; bus.m0_wdata = '0;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0002; bus.m1_wdata = '0;
        tick(); tick();
        checks++; if (bus.ram_cs_n !== 1'b1) begin failures++; $display("FAIL rst_cs_n got=%b exp=1", bus.ram_cs_n); end
        checks++; if (bus.ram_we_n !== 1'b1) begin failures++; $display("FAIL rst_we_n got=%b exp=1", bus.ram_we_n); end
        checks++; if ({bus.ram_oe, bus.ram_wdata_en} !== 2'b00) begin failures++; $display("FAIL rst_oe_wen got=%b exp=00", {bus.ram_oe, bus.ram_wdata_en}); end
        checks++; if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.busy} !== 5'b0) begin failures++; $display("FAIL rst_gnt_busy got=%b exp=00000", {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.busy}); end
        checks++; if ({bus.ram_addr, bus.ram_wdata, bus.m0_rdata, bus.m1_rdata} !== '0) begin failures++; $display("FAIL rst_data got addr=%h wd=%h r0=%h r1=%h exp=0", bus.ram_addr, bus.ram_wdata, bus.m0_rdata, bus.m1_rdata); end
        rst = 1'b0;
        tick();
        checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin failures++; $display("FAIL rst_first_gnt got=%b exp=10", {bus.m0_gnt, bus.m1_gnt}); end
        checks++; if (bus.ram_addr !== 16'h0001) begin failures++; $display("FAIL rst_first_addr got=%h exp=0001", bus.ram_addr); end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_write_read();
        bus.m0_we = 1'b1; bus.m0_addr = 16'h0005; bus.m0_wdata = 32'hDEADBEEF; bus.m0_req = 1'b1;
        tick();
        checks++; if ({bus.m0_gnt, bus.m1_gnt, bus.ram_cs_n, bus.ram_we_n, bus.ram_wdata_en, bus.ram_oe, bus.busy} !== 7'b1000101) begin
            failures++; $display("FAIL wr_access ctl got=%b exp=1000101", {bus.m0_gnt, bus.m1_gnt, bus.ram_cs_n, bus.ram_we_n, bus.ram_wdata_en, bus.ram_oe, bus.busy}); end
        checks++; if ({bus.ram_addr, bus.ram_wdata} !== {16'h0005, 32'hDEADBEEF}) begin failures++; $display("FAIL wr_addr_data got=%h/%h exp=0005/deadbeef", bus.ram_addr, bus.ram_wdata); end
        bus.m0_req = 1'b0;
        tick();
        checks++; if ({bus.m0_gnt, bus.ram_cs_n, bus.ram_wdata_en, bus.busy} !== 4'b0100) begin failures++; $display("FAIL wr_done got=%b exp=0100", {bus.m0_gnt, bus.ram_cs_n, bus.ram_wdata_en, bus.busy}); end
        bus.m0_we = 1'b0; bus.m0_req = 1'b1;
        tick();
        checks++; if ({bus.m0_gnt, bus.ram_cs_n, bus.ram_we_n, bus.ram_wdata_en, bus.ram_oe} !== 5'b10100) begin failures++; $display("FAIL rd_access got=%b exp=10100", {bus.m0_gnt, bus.ram_cs_n, bus.ram_we_n, bus.ram_wdata_en, bus.ram_oe}); end
        bus.m0_req = 1'b0;
        tick();
        checks++; if ({bus.m0_gnt, bus.ram_cs_n, bus.ram_we_n, bus.ram_oe, bus.ram_wdata_en, bus.m0_rvalid, bus.busy} !== 7'b0011001) begin
            failures++; $display("FAIL rd_wait got=%b exp=0011001", {bus.m0_gnt, bus.ram_cs_n, bus.ram_we_n, bus.ram_oe, bus.ram_wdata_en, bus.m0_rvalid, bus.busy}); end
        tick();
        checks++; if ({bus.m0_rvalid, bus.m1_rvalid, bus.busy} !== 3'b100) begin failures++; $display("FAIL rd_rvalid got=%b exp=100", {bus.m0_rvalid, bus.m1_rvalid, bus.busy}); end
        checks++; if (bus.m0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_rdata got=%h exp=deadbeef", bus.m0_rdata); end
        tick();
        checks++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00 || bus.m0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_hold got rv=%b%b rd=%h exp=00/deadbeef", bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata); end
    endtask

    task automatic test_alternate();
        int ngr = 0;
        int nrv = 0;
        rst = 1'b1; tick(); rst = 1'b0;
        bus.m0_we = 1'b1; bus.m0_addr = 16'h0000; bus.m0_wdata = 32'h100; bus.m0_req = 1'b1;
        bus.m1_we = 1'b0; bus.m1_addr = 16'h0000; bus.m1_req = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            checks++; if ((bus.ram_oe & bus.ram_wdata_en) !== 1'b0) begin failures++; $display("FAIL alt_bus_safety cycle=%0d got oe&wen=1 exp=0", c); end
            if (bus.m0_gnt || bus.m1_gnt) begin
                checks++;
                if ({bus.m0_gnt, bus.m1_gnt} !== ((ngr % 2 == 0) ? 2'b10 : 2'b01)) begin
                    failures++; $display("FAIL alt_order grant=%0d got=%b exp=%b", ngr, {bus.m0_gnt, bus.m1_gnt}, (ngr % 2 == 0) ? 2'b10 : 2'b01); end
                if (bus.m0_gnt) begin bus.m0_addr = bus.m0_addr + 16'h1; bus.m0_wdata = bus.m0_wdata + 32'h1; end
                ngr++;
            end
            if (bus.m1_rvalid) begin
                checks++; if (bus.m1_rdata !== 32'h00000100) begin failures++; $display("FAIL alt_m1_rdata got=%h exp=00000100", bus.m1_rdata); end
                nrv++;
            end
        end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        checks++; if (ngr !== 6) begin failures++; $display("FAIL alt_grant_count got=%0d exp=6", ngr); end
        checks++; if (nrv !== 3) begin failures++; $display("FAIL alt_rvalid_count got=%0d exp=3", nrv); end
        tick(); tick(); tick();
    endtask

    task automatic test_back_to_back();
        int nrv = 0;
        int ngr = 0;
        int t_rv[2];
        logic [31:0] exp_d[2];
        logic [15:0] exp_a[2];
        exp_d[0] = 32'hAAAA5555; exp_d[1] = 32'h12345678;
        exp_a[0] = 16'hFFFF;     exp_a[1] = 16'h0000;
        t_rv[0] = 0; t_rv[1] = 0;
        preload(16'hFFFF, 32'hAAAA5555);
        preload(16'h0000, 32'h12345678);
        bus.m1_we = 1'b0; bus.m1_addr = 16'hFFFF; bus.m1_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (bus.m1_gnt && ngr < 2) begin
                checks++; if (bus.ram_addr !== exp_a[ngr]) begin failures++; $display("FAIL b2b_addr grant=%0d got=%h exp=%h", ngr, bus.ram_addr, exp_a[ngr]); end
                if (ngr == 0) bus.m1_addr = 16'h0000; else bus.m1_req = 1'b0;
                ngr++;
            end
            if (bus.m1_rvalid && nrv < 2) begin
                checks++; if (bus.m1_rdata !== exp_d[nrv]) begin failures++; $display("FAIL b2b_rdata read=%0d got=%h exp=%h", nrv, bus.m1_rdata, exp_d[nrv]); end
                t_rv[nrv] = c;
                nrv++;
            end
        end
        bus.m1_req = 1'b0;
        checks++; if (nrv !== 2) begin failures++; $display("FAIL b2b_rvalid_count got=%0d exp=2", nrv); end
        checks++; if (t_rv[1] - t_rv[0] !== 3) begin failures++; $display("FAIL b2b_spacing got=%0d exp=3", t_rv[1] - t_rv[0]); end
        checks++; if (t_rv[0] !== 3) begin failures++; $display("FAIL b2b_latency got=%0d exp=3", t_rv[0]); end
        tick(); tick();
    endtask

    task automatic test_reset_in_rdwait();
        bus.m0_we = 1'b0; bus.m0_addr = 16'h0005; bus.m0_req = 1'b1;
        tick();
        checks++; if (bus.m0_gnt !== 1'b1) begin failures++; $display("FAIL rrw_gnt got=%b exp=1", bus.m0_gnt); end
        bus.m0_req = 1'b0;
        tick();
        checks++; if (bus.ram_oe !== 1'b1) begin failures++; $display("FAIL rrw_oe got=%b exp=1", bus.ram_oe); end
        rst = 1'b1;
        tick();
        checks++; if ({bus.m0_rvalid, bus.ram_oe, bus.ram_cs_n, bus.busy, bus.m0_gnt} !== 5'b00100) begin
            failures++; $display("FAIL rrw_abort got=%b exp=00100", {bus.m0_rvalid, bus.ram_oe, bus.ram_cs_n, bus.busy, bus.m0_gnt}); end
        checks++; if (bus.m0_rdata !== 32'h0) begin failures++; $display("FAIL rrw_rdata got=%h exp=0", bus.m0_rdata); end
        rst = 1'b0;
        tick();
        checks++; if (bus.m0_rvalid !== 1'b0) begin failures++; $display("FAIL rrw_no_rvalid got=%b exp=0", bus.m0_rvalid); end
        bus.m0_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0000; bus.m1_req = 1'b1;
        tick();
        checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin failures++; $display("FAIL rrw_prio got=%b exp=10", {bus.m0_gnt, bus.m1_gnt}); end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_req_pulse();
        bus.m1_we = 1'b1; bus.m1_addr = 16'h0020; bus.m1_wdata = 32'h0BADF00D; bus.m1_req = 1'b1;
        tick();
        checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) begin failures++; $display("FAIL pulse_m1_gnt got=%b exp=01", {bus.m0_gnt, bus.m1_gnt}); end
        bus.m1_req = 1'b0;
        bus.m0_we = 1'b1; bus.m0_addr = 16'h0030; bus.m0_wdata = 32'h55555555; bus.m0_req = 1'b1;
        tick();
        bus.m0_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if ({bus.m0_gnt, bus.ram_cs_n, bus.busy} !== 3'b010) begin failures++; $display("FAIL pulse_no_access cycle=%0d got=%b exp=010", c, {bus.m0_gnt, bus.ram_cs_n, bus.busy}); end
        end
    endtask

    initial begin
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        test_reset();
        test_write_read();
        test_alternate();
        test_back_to_back();
        test_reset_in_rdwait();
        test_req_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
